// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the single-issue RISC-V core.
// Walks FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK] -> PC_UPDATE per
// instruction, traps on an illegal opcode or a data-memory timeout, and counts
// retired instructions.
// Ports:
//   Clock, peripheral_reset          clock, async active-high reset
//   start, halt_req                  run control
//   inst_in, imem_ack                instruction fetch return
//   dmem_ack, branch_taken           data memory completion, ALU branch result
//   imem_req, dmem_req               memory request handshakes
//   en_inst_decode, decode_out,
//   exec_en, write_back_out          per-stage strobes
//   pc_inc_en, pc_branch_en          PC update enables
//   busy, trap, trap_cause           status
//   retired_count                    retired-instruction counter
module core_sequencer #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic             Clock,
    input  logic             peripheral_reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic [31:0]      inst_in,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             en_inst_decode,
    output logic             decode_out,
    output logic             exec_en,
    output logic             dmem_req,
    output logic             write_back_out,
    output logic             pc_inc_en,
    output logic             pc_branch_en,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired_count
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_R  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_L  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_S  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_SB = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
        S_MEM, S_WRITEBACK, S_PC_UPDATE, S_TRAP
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              br_flag_q, br_flag_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic imem_req_q, imem_req_d;
    logic en_dec_q, en_dec_d;
    logic exec_en_q, exec_en_d;
    logic dmem_req_q, dmem_req_d;
    logic wb_q, wb_d;
    logic pc_inc_q, pc_inc_d;
    logic pc_br_q, pc_br_d;
    logic busy_q, busy_d;
    logic trap_q, trap_d;

    logic is_sb, is_mem, is_legal;

    // Only the opcode field of the instruction matters here.
    logic unused_inst_hi;
    assign unused_inst_hi = ^inst_in[31:OP_W];

    assign is_sb    = (opcode_q == OP_SB);
    assign is_mem   = (opcode_q == OP_L) || (opcode_q == OP_S);
    assign is_legal = (opcode_q == OP_R) || (opcode_q == OP_I) || is_mem || is_sb;

    // Next-state, datapath-register and registered-output decode.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        to_d      = to_q;
        br_flag_d = br_flag_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    opcode_d = inst_in[OP_W-1:0];
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_EXECUTE: begin
                if (is_sb) begin
                    br_flag_d = branch_taken;
                    state_d   = S_PC_UPDATE;
                end else if (is_mem) begin
                    to_d    = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                to_d = to_q + TO_W'(1);
                // An ack in the final allowed cycle still completes the access.
                if (dmem_ack) begin
                    state_d = S_WRITEBACK;
                end else if (to_q == TO_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_WRITEBACK: begin
                state_d = S_PC_UPDATE;
            end
            S_PC_UPDATE: begin
                state_d = halt_req ? S_IDLE : S_FETCH;
            end
            S_TRAP: begin
                if (start) begin
                    cause_d = 2'b00;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Retire is counted on entry so the count moves with the PC enable.
        if (state_d == S_PC_UPDATE) cnt_d = cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so they register alongside it.
        imem_req_d = (state_d == S_FETCH);
        en_dec_d   = (state_d == S_DECODE);
        exec_en_d  = (state_d == S_EXECUTE);
        dmem_req_d = (state_d == S_MEM);
        wb_d       = (state_d == S_WRITEBACK);
        pc_br_d    = (state_d == S_PC_UPDATE) && is_sb && br_flag_d;
        pc_inc_d   = (state_d == S_PC_UPDATE) && !(is_sb && br_flag_d);
        busy_d     = (state_d != S_IDLE) && (state_d != S_TRAP);
        trap_d     = (state_d == S_TRAP);
    end

    // State and output registers.
    always_ff @(posedge Clock or posedge peripheral_reset) begin
        if (peripheral_reset) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            to_q       <= '0;
            br_flag_q  <= 1'b0;
            cause_q    <= 2'b00;
            cnt_q      <= '0;
            imem_req_q <= 1'b0;
            en_dec_q   <= 1'b0;
            exec_en_q  <= 1'b0;
            dmem_req_q <= 1'b0;
            wb_q       <= 1'b0;
            pc_inc_q   <= 1'b0;
            pc_br_q    <= 1'b0;
            busy_q     <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            to_q       <= to_d;
            br_flag_q  <= br_flag_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
            imem_req_q <= imem_req_d;
            en_dec_q   <= en_dec_d;
            exec_en_q  <= exec_en_d;
            dmem_req_q <= dmem_req_d;
            wb_q       <= wb_d;
            pc_inc_q   <= pc_inc_d;
            pc_br_q    <= pc_br_d;
            busy_q     <= busy_d;
            trap_q     <= trap_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign en_inst_decode = en_dec_q;
    assign decode_out     = en_dec_q;
    assign exec_en        = exec_en_q;
    assign dmem_req       = dmem_req_q;
    assign write_back_out = wb_q;
    assign pc_inc_en      = pc_inc_q;
    assign pc_branch_en   = pc_br_q;
    assign busy           = busy_q;
    assign trap           = trap_q;
    assign trap_cause     = cause_q;
    assign retired_count  = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. Each directed instruction is
// expanded from its class, ack delays and branch outcome into the expected
// per-cycle output words; a compare process checks every cycle against them.
module tb_core_sequencer;

    localparam int unsigned TMO = 16;

    logic        Clock;
    logic        peripheral_reset;
    logic        start, halt_req, imem_ack, dmem_ack, branch_taken;
    logic [31:0] inst_in;
    logic        imem_req, en_inst_decode, decode_out, exec_en, dmem_req;
    logic        write_back_out, pc_inc_en, pc_branch_en, busy, trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired_count;

    core_sequencer #(.CNT_W(32), .MEM_TIMEOUT(TMO), .TO_W(5)) dut (
        .Clock(Clock), .peripheral_reset(peripheral_reset),
        .start(start), .halt_req(halt_req), .inst_in(inst_in),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
        .imem_req(imem_req), .en_inst_decode(en_inst_decode),
        .decode_out(decode_out), .exec_en(exec_en), .dmem_req(dmem_req),
        .write_back_out(write_back_out), .pc_inc_en(pc_inc_en),
        .pc_branch_en(pc_branch_en), .busy(busy), .trap(trap),
        .trap_cause(trap_cause), .retired_count(retired_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // {imem_req, en_inst_decode, decode_out, exec_en, dmem_req,
    //  write_back_out, pc_inc_en, pc_branch_en, busy, trap}
    localparam logic [9:0] V_IDLE  = 10'b0000000000;
    localparam logic [9:0] V_FETCH = 10'b1000000010;
    localparam logic [9:0] V_DEC   = 10'b0110000010;
    localparam logic [9:0] V_EXEC  = 10'b0001000010;
    localparam logic [9:0] V_MEM   = 10'b0000100010;
    localparam logic [9:0] V_WB    = 10'b0000010010;
    localparam logic [9:0] V_PCI   = 10'b0000001010;
    localparam logic [9:0] V_PCB   = 10'b0000000110;
    localparam logic [9:0] V_TRAP  = 10'b0000000001;

    localparam logic [31:0] I_R   = 32'h00208033;
    localparam logic [31:0] I_I   = 32'h00100093;
    localparam logic [31:0] I_L   = 32'h00012083;
    localparam logic [31:0] I_S   = 32'h0020a023;
    localparam logic [31:0] I_SB  = 32'h00208463;
    localparam logic [31:0] I_BAD = 32'h0000007f;

    typedef struct packed {
        logic [9:0]  v;
        logic [1:0]  cause;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks;
    int          failures;
    int          cyc_n;
    logic [1:0]  m_cause;
    logic [31:0] m_cnt;
    logic [9:0]  dut_vec;

    assign dut_vec = {imem_req, en_inst_decode, decode_out, exec_en, dmem_req,
                      write_back_out, pc_inc_en, pc_branch_en, busy, trap};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the expected-output queue.
    initial begin
        cyc_n = 0;
        forever begin
            @(posedge Clock);
            #2;
            cyc_n++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("strobes@cyc%0d", cyc_n), 32'(dut_vec), 32'(e.v));
                chk($sformatf("trap_cause@cyc%0d", cyc_n), 32'(trap_cause), 32'(e.cause));
                chk($sformatf("retired@cyc%0d", cyc_n), retired_count, e.cnt);
            end
        end
    end

    // Drive inputs for the next edge and record the outputs expected after it.
    task automatic cyc(input logic st, input logic hl, input logic ia, input logic da,
                       input logic br, input logic [9:0] v);
        @(negedge Clock);
        start        = st;
        halt_req     = hl;
        imem_ack     = ia;
        dmem_ack     = da;
        branch_taken = br;
        exp_q.push_back(exp_t'{v, m_cause, m_cnt});
    endtask

    task automatic do_reset();
        @(negedge Clock);
        peripheral_reset = 1'b1;
        start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        m_cnt   = '0;
        m_cause = 2'b00;
        #1;
        chk("reset_strobes", 32'(dut_vec), 32'(V_IDLE));
        chk("reset_cause", 32'(trap_cause), 32'd0);
        chk("reset_retired", retired_count, 32'd0);
        exp_q.push_back(exp_t'{V_IDLE, m_cause, m_cnt});
        @(negedge Clock);
        peripheral_reset = 1'b0;
        exp_q.push_back(exp_t'{V_IDLE, m_cause, m_cnt});
    endtask

    // Run one instruction starting from FETCH. ddly < 0 means no dmem_ack;
    // noise drives start/halt_req high wherever they must be ignored.
    task automatic run(input logic [31:0] inst, input int idly, input int ddly,
                       input logic br, input logic noise, input logic halt);
        logic [6:0] op;
        logic       legal, is_sb, is_mem;
        op     = inst[6:0];
        is_sb  = (op == 7'b1100011);
        is_mem = (op == 7'b0000011) || (op == 7'b0100011);
        legal  = is_sb || is_mem || (op == 7'b0110011) || (op == 7'b0010011);
        inst_in = inst;
        for (int i = 0; i < idly; i++) cyc(noise, noise, 1'b0, 1'b0, 1'b0, V_FETCH);
        cyc(noise, noise, 1'b1, 1'b0, 1'b0, V_DEC);
        if (!legal) begin
            m_cause = 2'b01;
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_TRAP);
            return;
        end
        cyc(noise, noise, 1'b0, 1'b0, 1'b0, V_EXEC);
        if (is_sb) begin
            m_cnt++;
            cyc(noise, noise, 1'b0, 1'b0, br, br ? V_PCB : V_PCI);
        end else begin
            if (is_mem) begin
                cyc(noise, noise, 1'b0, 1'b0, br, V_MEM);
                for (int k = 1; k <= int'(TMO); k++) begin
                    if (k == ddly + 1) begin
                        cyc(noise, noise, 1'b0, 1'b1, 1'b0, V_WB);
                        break;
                    end else if (k == int'(TMO)) begin
                        m_cause = 2'b10;
                        cyc(noise, noise, 1'b0, 1'b0, 1'b0, V_TRAP);
                        return;
                    end else begin
                        cyc(noise, noise, 1'b0, 1'b0, 1'b0, V_MEM);
                    end
                end
            end else begin
                cyc(noise, noise, 1'b0, 1'b0, br, V_WB);
            end
            m_cnt++;
            cyc(noise, noise, 1'b0, 1'b0, 1'b0, V_PCI);
        end
        cyc(1'b0, halt, 1'b0, 1'b0, 1'b0, halt ? V_IDLE : V_FETCH);
    endtask

    initial begin
        checks = 0; failures = 0;
        peripheral_reset = 1'b1;
        start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        branch_taken = 1'b0; inst_in = '0;
        m_cnt = '0; m_cause = 2'b00;

        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_FETCH);

        run(I_R, 0, -1, 1'b1, 1'b0, 1'b0);
        @(posedge Clock); #3;
        chk("retired_after_r", retired_count, 32'd1);

        run(I_L, 2, 3, 1'b0, 1'b0, 1'b0);
        run(I_SB, 0, -1, 1'b1, 1'b0, 1'b0);
        run(I_SB, 1, -1, 1'b0, 1'b0, 1'b0);
        run(I_S, 1, 15, 1'b0, 1'b1, 1'b0);

        // Store that never completes: timeout trap.
        run(I_S, 0, -1, 1'b0, 1'b0, 1'b0);
        @(posedge Clock); #3;
        chk("timeout_trap", 32'(trap), 32'd1);
        chk("timeout_cause", 32'(trap_cause), 32'd2);
        chk("timeout_busy", 32'(busy), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_TRAP);
        m_cause = 2'b00;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_FETCH);

        // Illegal opcode trap, then restart.
        run(I_BAD, 0, -1, 1'b0, 1'b0, 1'b0);
        @(posedge Clock); #3;
        chk("illegal_cause", 32'(trap_cause), 32'd1);
        chk("retired_before_restart", retired_count, 32'd5);
        m_cause = 2'b00;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_FETCH);
        @(posedge Clock); #3;
        chk("restart_imem_req", 32'(imem_req), 32'd1);
        chk("restart_cause", 32'(trap_cause), 32'd0);

        // Abort with reset in the middle of a load's MEM wait.
        inst_in = I_L;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_DEC);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_EXEC);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_MEM);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_MEM);
        @(posedge Clock); #3;
        chk("mid_mem_dmem_req", 32'(dmem_req), 32'd1);
        do_reset();

        // Back-to-back I-types, halt at the second retire.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_FETCH);
        run(I_I, 0, -1, 1'b0, 1'b1, 1'b0);
        run(I_I, 0, -1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, V_IDLE);
        @(posedge Clock); #3;
        chk("halt_retired", retired_count, 32'd2);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_no_fetch", 32'(imem_req), 32'd0);
        @(negedge Clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue RISC-V core.
- Sequences fetch, decode, execute, data-memory access, write-back and PC update for R/I/L/S/SB instructions.
- Drives the instruction decoder's `en_inst_decode`, `decode_in` and `write_back_in` strobes, the PC update enables, and the instruction/data memory request handshakes.
- Traps on an illegal opcode or a data-memory timeout, and counts retired instructions.

Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.
- `MEM_TIMEOUT`, 16, maximum cycles spent in MEM waiting for `dmem_ack` before trapping (must be at least 1).
- `TO_W`, 5, width of the timeout counter (must satisfy 2^TO_W > MEM_TIMEOUT).

Ports:
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `peripheral_reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin execution from IDLE or TRAP.
- `halt_req`  in  1  stop after the current instruction retires.
- `inst_in`  in  32  fetched instruction; only bits [6:0] are used.
- `imem_ack`  in  1  instruction memory data valid.
- `dmem_ack`  in  1  data memory access complete.
- `branch_taken`  in  1  ALU branch compare result, valid in EXECUTE.
- `imem_req`  out  1  instruction fetch request.
- `en_inst_decode`  out  1  decoder field-latch enable.
- `decode_out`  out  1  read-enable strobe to the decoder's `decode_in`.
- `exec_en`  out  1  ALU execute strobe.
- `dmem_req`  out  1  data memory request.
- `write_back_out`  out  1  write strobe to the decoder's `write_back_in`.
- `pc_inc_en`  out  1  PC <- PC+4.
- `pc_branch_en`  out  1  PC <- PC+branch immediate.
- `busy`  out  1  high in any state other than IDLE and TRAP.
- `trap`  out  1  high while in TRAP.
- `trap_cause`  out  2  trap reason: 00 none, 01 illegal opcode, 10 dmem timeout.
- `retired_count`  out  CNT_W  number of instructions completed.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, PC_UPDATE, TRAP.
- All outputs are registered Moore decodes of the state. They change on the rising edge, so the decoder sees them stable at its falling edge.
- Reset: state = IDLE. Every output is 0, including `trap_cause` = 00 and `retired_count` = 0. The latched opcode is 0 and the timeout counter is 0. Reset mid-instruction aborts immediately with no further strobes.
- IDLE: `start` = 1 -> FETCH. Otherwise hold.
- FETCH: `imem_req` = 1. Hold until `imem_ack` = 1, then latch `inst_in[6:0]` into the opcode register and go to DECODE. No timeout applies to fetch.
- DECODE: `en_inst_decode` = `decode_out` = 1 for exactly one cycle.
  - Latched opcode in {0110011, 0010011, 0000011, 0100011, 1100011} -> EXECUTE.
  - Any other opcode -> TRAP with `trap_cause` = 01.
- EXECUTE: `exec_en` = 1 for one cycle. `branch_taken` is sampled into a flag only when the opcode is SB.
  - L or S -> MEM.
  - R or I -> WRITEBACK.
  - SB -> PC_UPDATE (no write-back).
- MEM: `dmem_req` = 1. The timeout counter clears on entry and increments each cycle.
  - `dmem_ack` = 1 -> WRITEBACK.
  - Counter reaching MEM_TIMEOUT without `dmem_ack` -> TRAP with `trap_cause` = 10.
  - `dmem_ack` arriving in the timeout cycle wins (no trap).
- WRITEBACK: `write_back_out` = 1 for one cycle, for R, I, L and S -> PC_UPDATE.
- PC_UPDATE: exactly one of the PC enables is 1.
  - `pc_branch_en` = 1 if the opcode is SB and the branch flag is set.
  - `pc_inc_en` = 1 otherwise.
  - `retired_count` increments by 1 and wraps modulo 2^CNT_W.
  - `halt_req` sampled high in this cycle -> IDLE; otherwise -> FETCH.
  - `halt_req` in any other state is ignored; assert it before retire.
- TRAP: `trap` = 1 and `busy` = 0. `trap_cause` holds; no strobes or PC updates occur.
  - `start` = 1 -> clear `trap_cause` to 00 and go to FETCH.
  - The PC is not reset by this block.
- `start` is ignored outside IDLE and TRAP.
- Cycle counts with immediate acks:
  - R/I: 5 cycles per instruction (FETCH..PC_UPDATE without MEM).
  - L/S: 6 cycles per instruction.
  - SB: 4 cycles per instruction.

Test Plan:
- Reset asserted mid-MEM with `dmem_req` = 1 -> all outputs 0 asynchronously, state IDLE, `retired_count` = 0.
- `start`, then R-type 0x00208033 with `imem_ack` in the first FETCH cycle -> exactly one `en_inst_decode`/`decode_out` pulse, one `exec_en`, one `write_back_out`, one `pc_inc_en`. Retire 5 cycles after FETCH entry; `retired_count` = 1.
- L-type 0x00012083 with `dmem_ack` delayed 3 cycles -> `dmem_req` high 4 cycles, then `write_back_out` and `pc_inc_en`.
- SB-type 0x00208463 with `branch_taken` = 1 -> `pc_branch_en` = 1, `pc_inc_en` = 0, `write_back_out` never asserted. Repeat with `branch_taken` = 0 -> `pc_inc_en` = 1.
- Opcode 0x7F -> TRAP after DECODE, `trap_cause` = 01, no `exec_en`. Then `start` -> `trap_cause` = 00, `imem_req` = 1. Separately, S-type with no `dmem_ack` and MEM_TIMEOUT = 16 -> TRAP with cause 10 after 16 MEM cycles; `dmem_ack` in cycle 16 -> no trap.
- Back-to-back I-types with `halt_req` pulsed in the second PC_UPDATE -> `retired_count` = 2, state IDLE, `busy` = 0, no further `imem_req`.
